// File: rtl/updown_counter_n.sv
// updown_counter_n: parametrised load / up / down counter with a small
// command FSM, selectable wrap or saturate arithmetic, a free-running
// count mode, hold and clear, and registered overflow/underflow pulses.
//
// Optional build feature: define UPDOWN_COUNTER_STICKY_EN to add
// ovf_sticky / unf_sticky flags and their sticky_clr input.
//
// Handshake: there is no valid/ready pair. Commands are level inputs
// sampled at every rising edge. The highest-priority command wins:
// clr > load > inc > dec > stop.
module updown_counter_n #(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              load,
    input  logic              inc,
    input  logic              dec,
    input  logic              stop,
    input  logic [WIDTH-1:0]  d_in,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  count,
    output logic [2:0]        state,
    output logic              zero,
    output logic              ovf,
    output logic              unf
`ifdef UPDOWN_COUNTER_STICKY_EN
    ,
    input  logic              sticky_clr,
    output logic              ovf_sticky,
    output logic              unf_sticky
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_INC  = 3'b010,
        S_DEC  = 3'b100,
        S_HOLD = 3'b101
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  count_q;
    logic [WIDTH-1:0]  count_d;
    logic              ovf_q;
    logic              unf_q;
    logic              ovf_d;
    logic              unf_d;
    logic [WIDTH:0]    step_ext;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;

    assign state = state_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign zero  = (count_q == '0);

    // Next state: prioritised command decode, otherwise per-state default.
    always_comb begin
        state_d = S_IDLE;
        if (clr)       state_d = S_IDLE;
        else if (load) state_d = S_LOAD;
        else if (inc)  state_d = S_INC;
        else if (dec)  state_d = S_DEC;
        else if (stop) state_d = S_HOLD;
        else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_LOAD:  state_d = S_HOLD;
                S_INC:   state_d = S_INC;
                S_DEC:   state_d = S_DEC;
                S_HOLD:  state_d = S_HOLD;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: the count acts on the state held before the edge, using
    // one extra bit so carry-out and borrow fall out of the top bit.
    always_comb begin
        step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
        sum      = {1'b0, count_q} + step_ext;
        diff     = {1'b0, count_q} - step_ext;
        count_d  = count_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        case (state_q)
            S_IDLE: count_d = '0;
            S_LOAD: count_d = d_in;
            S_INC: begin
                if (sum[WIDTH]) begin
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                end else begin
                    count_d = sum[WIDTH-1:0];
                end
            end
            S_DEC: begin
                if (diff[WIDTH]) begin
                    unf_d   = 1'b1;
                    count_d = SATURATE ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
                end else begin
                    count_d = diff[WIDTH-1:0];
                end
            end
            S_HOLD:  count_d = count_q;
            default: count_d = '0;
        endcase
    end

    // State, count and the one-cycle pulses share one register stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef UPDOWN_COUNTER_STICKY_EN
    logic ovf_sticky_q;
    logic unf_sticky_q;

    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;

    // Sticky flags: a new pulse beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            if (ovf_d)                  ovf_sticky_q <= 1'b1;
            else if (sticky_clr || clr) ovf_sticky_q <= 1'b0;
            if (unf_d)                  unf_sticky_q <= 1'b1;
            else if (sticky_clr || clr) unf_sticky_q <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
- Parametrised successor to the 8-bit load/increment/decrement counter.
- Generalises width and step size, and adds selectable wrap or saturate arithmetic, a free-running count mode, hold and clear, and registered overflow/underflow pulses.
- Control FSM plus datapath in one block; used as a generic event/address counter in the datapath.

Parameters:
- WIDTH, 8, counter and load-data width (≥2).
- STEP_W, 4, width of step input (1..WIDTH).
- SATURATE, 0, 0 = modulo-2^WIDTH wrap; 1 = clamp at all-ones / zero.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear command
- load  input  1  load command
- inc  input  1  count-up command
- dec  input  1  count-down command
- stop  input  1  hold command: leave INC/DEC and freeze count
- d_in  input  WIDTH  load value
- step  input  STEP_W  unsigned step magnitude, sampled every counting cycle
- count  output  WIDTH  registered count
- state  output  3  current FSM state encoding
- zero  output  1  count == 0, from register
- ovf  output  1  one-cycle pulse, registered
- unf  output  1  one-cycle pulse, registered

Behaviour:
- Reset (reset_n low, async):
  - state = IDLE; count = 0; ovf = unf = 0.
  - zero = 1.
- State encoding: IDLE 3'b000, LOAD 3'b001, INC 3'b010, DEC 3'b100, HOLD 3'b101. Any other encoding goes to IDLE on the next edge.
- Next state: command priority is clr > load > inc > dec > stop.
  - clr → IDLE.
  - load → LOAD.
  - inc → INC.
  - dec → DEC.
  - stop → HOLD.
  - No command:
    - INC and DEC stay in their state (free-running).
    - LOAD → HOLD.
    - IDLE and HOLD stay.
- Count update at each edge, by the state held before the edge:
  - IDLE: count ← 0.
  - LOAD: count ← d_in, sampled that cycle.
  - INC: count ← count + step.
  - DEC: count ← count − step.
  - HOLD: count unchanged.
- Latency: a command is sampled at edge k and sets state; count reflects it at edge k+1.
- Arithmetic: computed at WIDTH+1 bits with step zero-extended.
  - SATURATE=0:
    - Result is taken modulo 2^WIDTH.
    - ovf pulses on an INC carry-out.
    - unf pulses on a DEC borrow.
  - SATURATE=1:
    - INC result above 2^WIDTH−1 clamps to all-ones; ovf pulses.
    - DEC result below 0 clamps to 0; unf pulses.
    - ovf/unf also pulse on each further attempt while pinned at the limit with step ≠ 0.
- Step boundaries:
  - step = 0 in INC/DEC: count unchanged, no pulses.
  - Landing exactly on all-ones or 0 is not an overflow or underflow.
- ovf/unf are registered with count: high for exactly the one cycle after the offending edge, and never both high together.
- zero is derived combinationally from the count register.
- Simultaneous commands: only the highest-priority command takes effect. inc+dec together → INC.
- Reset mid-count: all outputs return to reset values immediately. The first edge after release acts from IDLE.

Optional Feature:
- Macro: UPDOWN_COUNTER_STICKY_EN.
- Defined:
  - Adds output ports ovf_sticky (1) and unf_sticky (1), plus input sticky_clr (1).
  - Each sticky flag sets on its pulse and holds until sticky_clr or clr. Set wins over a same-cycle sticky_clr.
  - Both reset to 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle: reset_n low then high, no commands → count = 0x00, zero = 1, state = 000, ovf = unf = 0 for 5 cycles.
- Load and hold: d_in = 0x5A, load for 1 cycle → next edge count = 0x5A; state LOAD then HOLD; count remains 0x5A.
- Wrap (SATURATE=0):
  - Load 0xFC, then inc with step = 3: count goes 0xFF, then 0x02 with a 1-cycle ovf.
  - DEC from 0x01 with step = 2 → 0xFF, 1-cycle unf.
- Saturate (SATURATE=1):
  - Load 0xFC, then inc with step = 5 → 0xFF with ovf. The next cycle holds 0xFF with ovf again.
  - stop → HOLD, ovf = 0.
- Priority and mid-op reset:
  - load+inc+dec asserted with d_in = 0x10 → LOAD, count = 0x10.
  - clr during INC → count 0 on the following edge.
  - reset_n pulsed low mid-INC → count = 0 asynchronously.
- Sticky (UPDOWN_COUNTER_STICKY_EN):
  - Overflow sets ovf_sticky = 1, which persists 10 cycles.
  - sticky_clr clears it.
  - Overflow coinciding with sticky_clr leaves ovf_sticky = 1.
